// File: rtl/i2c_apb_arb.sv
// +----------------------------------------------------------------------------+
// | i2c_apb_arb : round-robin two-requester APB arbiter with lock and timeout   |
// | rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module i2c_apb_arb #(
  parameter int unsigned LOCK_TMO = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        m0_sel,
  input  logic        m0_en,
  input  logic        m0_write,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m0_lock,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_sel,
  input  logic        m1_en,
  input  logic        m1_write,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_lock,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        apb_sel,
  output logic        apb_en,
  output logic        apb_write,
  output logic [31:0] apb_addr,
  output logic [31:0] apb_wdata,
  input  logic        apb_ready,
  input  logic [31:0] apb_rdata,
  output logic [1:0]  owner
);

  localparam int CW = (LOCK_TMO > 1) ? $clog2(LOCK_TMO) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'((LOCK_TMO > 0) ? LOCK_TMO - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t      state_q, state_d;
  logic        apb_sel_q, apb_sel_d;
  logic        apb_en_q, apb_en_d;
  logic        apb_write_q, apb_write_d;
  logic [31:0] apb_addr_q, apb_addr_d;
  logic [31:0] apb_wdata_q, apb_wdata_d;
  logic [1:0]  ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  owner_q, owner_d;
  logic        lock_held_q, lock_held_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        last_q, last_d;

  logic elig0, elig1, pick1, owner_sel, owner_lock;
  logic unused_en;

  // APB enable from the requesters carries no extra information for arbitration.
  assign unused_en = m0_en ^ m1_en;

  assign elig0      = m0_sel && (!lock_held_q || owner_q[0]);
  assign elig1      = m1_sel && (!lock_held_q || owner_q[1]);
  assign pick1      = elig1 && (!elig0 || !last_q);
  assign owner_sel  = (owner_q[0] & m0_sel) | (owner_q[1] & m1_sel);
  assign owner_lock = (owner_q[0] & m0_lock) | (owner_q[1] & m1_lock);

  always_comb begin
    state_d     = state_q;
    apb_sel_d   = apb_sel_q;
    apb_en_d    = apb_en_q;
    apb_write_d = apb_write_q;
    apb_addr_d  = apb_addr_q;
    apb_wdata_d = apb_wdata_q;
    ready_d     = 2'b00;
    rdata_d     = rdata_q;
    owner_d     = owner_q;
    lock_held_d = lock_held_q;
    cnt_d       = '0;
    last_d      = last_q;
    unique case (state_q)
      IDLE: begin
        if (elig0 || elig1) begin
          apb_sel_d   = 1'b1;
          apb_write_d = pick1 ? m1_write : m0_write;
          apb_addr_d  = pick1 ? m1_addr  : m0_addr;
          apb_wdata_d = pick1 ? m1_wdata : m0_wdata;
          owner_d     = pick1 ? 2'b10 : 2'b01;
          state_d     = SETUP;
        end else if (lock_held_q && !owner_sel && (LOCK_TMO != 0)) begin
          // Idle lock owner: count toward forced release.
          if (cnt_q == TMO_LAST) begin
            lock_held_d = 1'b0;
            owner_d     = 2'b00;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      SETUP: begin
        apb_en_d = 1'b1;
        state_d  = ACCESS;
      end
      ACCESS: begin
        if (apb_ready) begin
          apb_sel_d = 1'b0;
          apb_en_d  = 1'b0;
          rdata_d   = apb_rdata;
          ready_d   = owner_q;
          state_d   = RESP;
        end
      end
      RESP: begin
        lock_held_d = owner_lock;
        if (!owner_lock) owner_d = 2'b00;
        last_d  = owner_q[1];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      apb_sel_q   <= 1'b0;
      apb_en_q    <= 1'b0;
      apb_write_q <= 1'b0;
      apb_addr_q  <= '0;
      apb_wdata_q <= '0;
      ready_q     <= 2'b00;
      rdata_q     <= '0;
      owner_q     <= 2'b00;
      lock_held_q <= 1'b0;
      cnt_q       <= '0;
      last_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      apb_sel_q   <= apb_sel_d;
      apb_en_q    <= apb_en_d;
      apb_write_q <= apb_write_d;
      apb_addr_q  <= apb_addr_d;
      apb_wdata_q <= apb_wdata_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
      owner_q     <= owner_d;
      lock_held_q <= lock_held_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
    end
  end

  assign apb_sel   = apb_sel_q;
  assign apb_en    = apb_en_q;
  assign apb_write = apb_write_q;
  assign apb_addr  = apb_addr_q;
  assign apb_wdata = apb_wdata_q;
  assign m0_ready  = ready_q[0];
  assign m1_ready  = ready_q[1];
  assign m0_rdata  = rdata_q;
  assign m1_rdata  = rdata_q;
  assign owner     = owner_q;

endmodule

`default_nettype wire
